node_basic_fn: RTL and testbench

- Parametrised basic-function leaf node for the recursive-function evaluation tree.
- Generalises the fixed projection leaf to N inputs of W bits each.
- Evaluates zero, successor-of-input or projection-of-input, selected at run time.
- Has a programmable latency and an error flag.
- Keeps the tree's start/ready handshake: a rising edge of ST launches evaluation, and RD returns high when RES is valid.

---
 rtl/node_pkg.sv | 21 ++
 rtl/node_start_edge.sv | 20 ++
 rtl/node_basic_fn.sv | 124 ++++++++++++
 tb/tb_node_basic_fn.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/node_pkg.sv
// Shared definitions for the recursive-function evaluation tree nodes:
// function-mode and state encodings plus the start/ready handshake levels.
package node_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO = 2'd0,
    MODE_SUCC = 2'd1,
    MODE_PROJ = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // RD level seen by the parent node
  localparam logic RD_BUSY  = 1'b0;
  localparam logic RD_READY = 1'b1;

endpackage

// File: rtl/node_start_edge.sv
// Start-edge detector shared by all tree nodes. The previous-ST register keeps
// sampling while RST is low, so an ST held high across reset release is seen
// as "already high" and does not launch an evaluation.
module node_start_edge (
  input  logic CLK,
  input  logic RST,
  input  logic ST,
  output logic start
);

  logic st_old;

  // previous ST, sampled every cycle regardless of reset
  always_ff @(posedge CLK) begin
    st_old <= ST;
  end

  assign start = ST & ~st_old & RST;

endmodule

// File: rtl/node_basic_fn.sv
// Basic-function leaf node: zero, successor or projection of one of N W-bit
// operands, delivered LAT cycles after a rising edge of ST.
// Optional macro NODE_BASIC_FN_OVF_EN adds an OVF output flagging a wrapped
// successor result.
module node_basic_fn
  import node_pkg::*;
#(
  parameter int W     = 16,
  parameter int N     = 3,
  parameter int IDX_W = 2,
  parameter int LAT   = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ST,
  input  logic [1:0]       MODE,
  input  logic [IDX_W-1:0] SEL,
  input  logic [N*W-1:0]   IN,
  output logic             RD,
  output logic [W-1:0]     RES,
  output logic             ERR
`ifdef NODE_BASIC_FN_OVF_EN
  , output logic           OVF
`endif
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  logic             start;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Result is computed at the start edge and held, which is equivalent to
  // snapshotting MODE/SEL/operand: later input changes cannot affect it.
  logic [W-1:0]     op;
  logic             sel_ok;
  logic [W-1:0]     eval_res;
  logic             eval_err;
  logic [W-1:0]     snap_res;
  logic             snap_err;
`ifdef NODE_BASIC_FN_OVF_EN
  logic             eval_ovf;
  logic             snap_ovf;
`endif

  node_start_edge u_edge (
    .CLK   (CLK),
    .RST   (RST),
    .ST    (ST),
    .start (start)
  );

  // operand select and function evaluation on the live inputs
  always_comb begin
    op       = '0;
    sel_ok   = ({1'b0, SEL} < (IDX_W+1)'(N));
    eval_res = '0;
    eval_err = 1'b0;
`ifdef NODE_BASIC_FN_OVF_EN
    eval_ovf = 1'b0;
`endif
    for (int k = 0; k < N; k++) begin
      if (SEL == IDX_W'(k)) op = IN[k*W +: W];
    end
    case (mode_t'(MODE))
      MODE_ZERO: eval_res = '0;
      MODE_SUCC: begin
        if (sel_ok) begin
          eval_res = op + W'(1);
`ifdef NODE_BASIC_FN_OVF_EN
          eval_ovf = &op;
`endif
        end else begin
          eval_err = 1'b1;
        end
      end
      MODE_PROJ: begin
        if (sel_ok) eval_res = op;
        else        eval_err = 1'b1;
      end
      default:   eval_err = 1'b1;
    endcase
  end

  // sequencer: launch/restart on start, count down, publish on completion
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      RD       <= RD_READY;
      RES      <= '0;
      ERR      <= 1'b0;
      snap_res <= '0;
      snap_err <= 1'b0;
`ifdef NODE_BASIC_FN_OVF_EN
      OVF      <= 1'b0;
      snap_ovf <= 1'b0;
`endif
    end else if (start) begin
      // a start during RUN abandons the pending result
      snap_res <= eval_res;
      snap_err <= eval_err;
`ifdef NODE_BASIC_FN_OVF_EN
      snap_ovf <= eval_ovf;
`endif
      cnt      <= CNT_W'(LAT - 1);
      RD       <= RD_BUSY;
      state    <= S_RUN;
    end else if (state == S_RUN) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        RES   <= snap_res;
        ERR   <= snap_err;
`ifdef NODE_BASIC_FN_OVF_EN
        OVF   <= snap_ovf;
`endif
        RD    <= RD_READY;
        state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_node_basic_fn.sv
// Directed plus randomized bench for node_basic_fn. Two instances share
// operands: one with LAT=1, one with LAT=4, each with its own ST line.
module tb_node_basic_fn;

  logic        CLK = 1'b0;
  logic        RST;
  logic        st1, st4;
  logic [1:0]  MODE;
  logic [1:0]  SEL;
  logic [47:0] IN;
  logic        rd1, rd4, err1, err4;
  logic [15:0] res1, res4;
`ifdef NODE_BASIC_FN_OVF_EN
  logic        ovf1, ovf4;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  node_basic_fn #(.W(16), .N(3), .IDX_W(2), .LAT(1)) dut1 (
    .CLK(CLK), .RST(RST), .ST(st1), .MODE(MODE), .SEL(SEL), .IN(IN),
    .RD(rd1), .RES(res1), .ERR(err1)
`ifdef NODE_BASIC_FN_OVF_EN
    , .OVF(ovf1)
`endif
  );

  node_basic_fn #(.W(16), .N(3), .IDX_W(2), .LAT(4)) dut4 (
    .CLK(CLK), .RST(RST), .ST(st4), .MODE(MODE), .SEL(SEL), .IN(IN),
    .RD(rd4), .RES(res4), .ERR(err4)
`ifdef NODE_BASIC_FN_OVF_EN
    , .OVF(ovf4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ST high for exactly one edge (the start edge T); returns just after T
  task automatic pulse(input bit which4);
    if (which4) st4 = 1'b1; else st1 = 1'b1;
    tick();
    st1 = 1'b0;
    st4 = 1'b0;
  endtask

  // reference: {ovf, err, res} from the function definitions
  function automatic logic [17:0] model(input int mode, input int sel, input logic [47:0] in);
    int v;
    if (mode == 0) return 18'h0;
    if (mode == 3 || sel >= 3) return {1'b0, 1'b1, 16'h0};
    v = int'((in >> (16 * sel)) & 48'hFFFF);
    if (mode == 2) return {2'b00, v[15:0]};
    v = v + 1;
    return {(v >= 65536), 1'b0, 16'(v % 65536)};
  endfunction

  initial begin
    logic [17:0] e;
    int m, s;
    RST = 1'b0; st1 = 1'b1; st4 = 1'b1; MODE = 2'd0; SEL = 2'd0; IN = '0;

    // reset with ST held high across release
    repeat (3) tick();
    RST = 1'b1;
    tick();
    chk("rst_rd1", rd1, 1); chk("rst_res1", res1, 0); chk("rst_err1", err1, 0);
    chk("rst_rd4", rd4, 1); chk("rst_res4", res4, 0); chk("rst_err4", err4, 0);
`ifdef NODE_BASIC_FN_OVF_EN
    chk("rst_ovf4", ovf4, 0);
`endif
    repeat (5) tick();
    chk("hold_rd1", rd1, 1); chk("hold_rd4", rd4, 1);
    st1 = 1'b0; st4 = 1'b0;
    tick();

    // LAT=1 projection IN[2]
    IN = {16'h0003, 16'h00AA, 16'h1234};
    MODE = 2'd2; SEL = 2'd2;
    pulse(0);
    chk("p_busy", rd1, 0);
    tick();
    chk("p_rd", rd1, 1); chk("p_res", res1, 16'h0003); chk("p_err", err1, 0);

    // LAT=4 successor of all-ones wraps; IN changes after T
    IN = {16'h0003, 16'h00AA, 16'hFFFF};
    MODE = 2'd1; SEL = 2'd0;
    pulse(1);
    chk("s_busy0", rd4, 0);
    IN = {16'h0003, 16'h00AA, 16'h0010}; MODE = 2'd2;
    tick(); tick(); tick();
    chk("s_busy3", rd4, 0);
    tick();
    chk("s_rd", rd4, 1); chk("s_res", res4, 16'h0000); chk("s_err", err4, 0);
`ifdef NODE_BASIC_FN_OVF_EN
    chk("s_ovf", ovf4, 1);
`endif
    tick();

    // illegal select, then zero clears ERR, then reserved mode
    IN = {16'h0003, 16'h00AA, 16'h1234};
    MODE = 2'd2; SEL = 2'd3;
    pulse(0); tick();
    chk("il_res", res1, 0); chk("il_err", err1, 1);
    MODE = 2'd2; SEL = 2'd1;
    pulse(0); tick();
    chk("pr1_res", res1, 16'h00AA); chk("pr1_err", err1, 0);
    MODE = 2'd0;
    pulse(0); tick();
    chk("z_res", res1, 0); chk("z_err", err1, 0);
    MODE = 2'd3; SEL = 2'd0;
    pulse(0); tick();
    chk("rsvd_err", err1, 1); chk("rsvd_res", res1, 0);

    // restart at T+2 on LAT=4
    MODE = 2'd2; SEL = 2'd1;
    pulse(1);              // T
    tick();                // T+1
    SEL = 2'd2;
    pulse(1);              // T+2
    SEL = 2'd1;
    tick(); tick();        // T+4
    chk("rs_busy4", rd4, 0); chk("rs_res4", res4, 0);
    tick();                // T+5
    chk("rs_busy5", rd4, 0);
    tick();                // T+6
    chk("rs_rd", rd4, 1); chk("rs_res", res4, 16'h0003);

    // reset at T+2 aborts a LAT=4 run
    MODE = 2'd2; SEL = 2'd0;
    pulse(1);              // T
    tick();                // T+1
    RST = 1'b0;
    tick();                // T+2
    chk("ra_rd", rd4, 1); chk("ra_res", res4, 0);
    RST = 1'b1;
    tick(); tick(); tick(); // T+5
    chk("ra_rd_late", rd4, 1); chk("ra_res_late", res4, 0);

    // randomized evaluations on both instances
    for (int it = 0; it < 40; it++) begin
      m = int'($urandom_range(0, 3));
      s = int'($urandom_range(0, 3));
      IN = {16'($urandom), 16'($urandom), 16'($urandom)};
      if ($urandom_range(0, 3) == 0) IN[16*(s%3) +: 16] = 16'hFFFF;
      MODE = 2'(m); SEL = 2'(s);
      e = model(m, s, IN);
      st1 = 1'b1; st4 = 1'b1;
      tick();              // T
      st1 = 1'b0; st4 = 1'b0;
      IN = {16'($urandom), 16'($urandom), 16'($urandom)};
      MODE = 2'($urandom); SEL = 2'($urandom);
      tick();              // T+1
      chk("r1_rd", rd1, 1); chk("r1_res", res1, e[15:0]); chk("r1_err", err1, e[16]);
      chk("r4_busy", rd4, 0);
`ifdef NODE_BASIC_FN_OVF_EN
      chk("r1_ovf", ovf1, e[17]);
`endif
      tick(); tick(); tick(); // T+4
      chk("r4_rd", rd4, 1); chk("r4_res", res4, e[15:0]); chk("r4_err", err4, e[16]);
`ifdef NODE_BASIC_FN_OVF_EN
      chk("r4_ovf", ovf4, e[17]);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
